// File: rtl/adsr_note_sequencer_if.sv
// ---------------------------------------------------------------------------
// adsr_note_sequencer_if
//
// MMIO slot bus for the ADSR note sequencer.
//
// Bus semantics: a write happens in every cycle where cs & write are high,
// with addr/wr_data sampled on that rising clk edge. There is no wait state
// and no back-pressure. rd_data is combinational from addr and is valid
// whenever cs is high. Reads have no side effects, so read is informational.
//
// Signals:
//   cs       slot select
//   read     read strobe
//   write    write strobe
//   addr     register address (only addr[1:0] is decoded)
//   wr_data  write data
//   rd_data  read data, driven by the slave
// ---------------------------------------------------------------------------
interface adsr_note_sequencer_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/adsr_note_sequencer.sv
// ---------------------------------------------------------------------------
// adsr_note_sequencer
//
// Queues DDS frequency control words written over MMIO and plays them
// back-to-back through an ADSR envelope unit. For each note: pop an FCW and
// drive it onto focw, pulse adsr_start for one cycle, wait for the envelope
// to run (adsr_idle low, then high again), then hold a programmable silent
// gap before the next note.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   bus          MMIO slot bus (slave side)
//   adsr_idle    high while the ADSR unit is idle
//   adsr_start   one-cycle start pulse to the ADSR unit
//   focw         FCW of the current note, to the DDS
//   note_active  high from the start pulse until the envelope ends
//   state_dbg_o  current sequencer FSM state
//
// Register map (addr[1:0]):
//   0  W: push wr_data[FCW_W-1:0] into the note FIFO
//      R: {count @12:8, ovf @3, busy @2, full @1, empty @0}
//   1  RW: gap length in clk cycles (gap of N gives N+1 silent cycles)
//   2  W: run = wr_data[0], flush FIFO if wr_data[1], clear ovf if wr_data[2]
//      R: {31'b0, run}
//   3  R: current focw, zero-extended
// ---------------------------------------------------------------------------
module adsr_note_sequencer #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int FCW_W           = 26,
    parameter int BUSY_TIMEOUT    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    adsr_note_sequencer_if.slave bus,
    input  logic                 adsr_idle,
    output logic                 adsr_start,
    output logic [FCW_W-1:0]     focw,
    output logic                 note_active,
    output logic [2:0]           state_dbg_o
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_PLAY      = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    // ---------------------------------------------------------------------
    // Register decode
    // ---------------------------------------------------------------------
    logic wr_en;
    logic push_req;
    logic gap_we;
    logic ctrl_we;
    logic flush;

    assign wr_en    = bus.cs & bus.write;
    assign push_req = wr_en & (bus.addr[1:0] == 2'd0);
    assign gap_we   = wr_en & (bus.addr[1:0] == 2'd1);
    assign ctrl_we  = wr_en & (bus.addr[1:0] == 2'd2);
    assign flush    = ctrl_we & bus.wr_data[1];

    // read is informational only and the upper address bits are not decoded
    logic unused_bus;
    assign unused_bus = &{1'b0, bus.read, bus.addr[4:2]};

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    logic [31:0] gap_q;
    logic        run_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q <= '0;
            run_q <= 1'b0;
        end else begin
            if (gap_we) begin
                gap_q <= bus.wr_data;
            end
            if (ctrl_we) begin
                run_q <= bus.wr_data[0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Note FIFO
    // ---------------------------------------------------------------------
    logic [FCW_W-1:0]           mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       ovf_q, ovf_d;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       pop;
    logic                       push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

    // A push into a full FIFO still fits if the sequencer pops this cycle.
    assign push_ok = push_req & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (flush) begin
            // Flush wins over any push; a pop this cycle still hands its
            // entry to the sequencer before the queue is emptied.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (ctrl_we & bus.wr_data[2]) begin
            ovf_d = 1'b0;
        end else if (push_req & fifo_full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok & ~flush) begin
            mem_q[wr_ptr_q] <= bus.wr_data[FCW_W-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             note_active_q, note_active_d;
    logic [FCW_W-1:0] focw_q, focw_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            note_active_q <= 1'b0;
            focw_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            note_active_q <= note_active_d;
            focw_q        <= focw_d;
        end
    end

    // cnt_q is shared: busy-wait timeout in WAIT_BUSY, remaining gap in GAP.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        note_active_d = note_active_q;
        focw_d        = focw_q;
        pop           = 1'b0;
        adsr_start    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_q & ~fifo_empty & adsr_idle) begin
                    pop           = 1'b1;
                    focw_d        = mem_q[rd_ptr_q];
                    note_active_d = 1'b1;
                    state_d       = S_START;
                end
            end

            S_START: begin
                adsr_start = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (~adsr_idle) begin
                    state_d = S_PLAY;
                end else if (cnt_q + 32'd1 == 32'(BUSY_TIMEOUT)) begin
                    // Envelope never went busy: treat it as zero length.
                    note_active_d = 1'b0;
                    cnt_d         = gap_q;
                    state_d       = S_GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_PLAY: begin
                if (adsr_idle) begin
                    note_active_d = 1'b0;
                    cnt_d         = gap_q;
                    state_d       = S_GAP;
                end
            end

            S_GAP: begin
                // Gap length is latched on entry, so later gap writes only
                // affect the next note.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign focw        = focw_q;
    assign note_active = note_active_q;
    assign state_dbg_o = state_q;

    // ---------------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------------
    logic        busy;
    logic [31:0] rd_data;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        rd_data = '0;
        case (bus.addr[1:0])
            2'd0: begin
                rd_data[8 +: CW] = count_q;
                rd_data[3]       = ovf_q;
                rd_data[2]       = busy;
                rd_data[1]       = fifo_full;
                rd_data[0]       = fifo_empty;
            end
            2'd1:    rd_data = gap_q;
            2'd2:    rd_data[0] = run_q;
            default: rd_data[FCW_W-1:0] = focw_q;
        endcase
    end

    assign bus.rd_data = rd_data;

endmodule
